// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with default master, locked-transfer and fixed-burst hold,
// and SPLIT masking of masters until the slave releases them through HSPLIT.
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                   clock,
   input  logic                   HRESETn,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic                   HREADY,
   input  logic [1:0]             HRESP,
   input  logic [15:0]            HSPLIT,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [3:0]             HMASTER,
   output logic                   HMASTLOCK
);

   localparam logic [1:0]  TR_NONSEQ = 2'b10;
   localparam logic [1:0]  TR_SEQ    = 2'b11;
   localparam logic [1:0]  RSP_OKAY  = 2'b00;
   localparam logic [1:0]  RSP_SPLIT = 2'b11;
   localparam logic [3:0]  DEF_IDX   = 4'(DEFAULT_MASTER);
   localparam logic [15:0] VALID     = 16'((32'd1 << NUM_MASTERS) - 32'd1);
   localparam logic [NUM_MASTERS-1:0] GRANT_ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

   logic [3:0]             gidx;
   logic [3:0]             beats_left;
   logic [15:0]            split_mask;

   logic [3:0]             beats_nxt;
   logic [15:0]            split_set;
   logic [15:0]            split_nxt;
   logic [15:0]            lock_ext;
   logic [15:0]            elig;
   logic                   arb_ok;
   logic [3:0]             winner;
   logic [3:0]             idx;
   logic                   found;
   logic [NUM_MASTERS-1:0] grant_nxt;

   // Beats remaining after the first one: SINGLE/INCR 0, x4 3, x8 7, x16 15.
   function automatic logic [3:0] burst_last(input logic [2:0] burst);
      logic [3:0] last;
      case (burst[2:1])
         2'b00:   last = 4'd0;
         2'b01:   last = 4'd3;
         2'b10:   last = 4'd7;
         default: last = 4'd15;
      endcase
      return last;
   endfunction

   always_comb begin
      beats_nxt = beats_left;
      if (HREADY) begin
         if (HRESP != RSP_OKAY)
            beats_nxt = 4'd0;
         else if (HTRANS == TR_NONSEQ)
            beats_nxt = burst_last(HBURST);
         else if (HTRANS == TR_SEQ && beats_left != 4'd0)
            beats_nxt = beats_left - 4'd1;
      end
   end

   // A new SPLIT on the owning master outranks a release arriving in the same cycle.
   always_comb begin
      split_set = 16'd0;
      if (HRESP == RSP_SPLIT && !HREADY)
         split_set = 16'd1 << HMASTER;
      split_nxt = ((split_mask & ~HSPLIT) | split_set) & VALID;
   end

   assign lock_ext = 16'(HLOCK);
   assign elig     = 16'(HBUSREQ) & ~split_mask & VALID;
   assign arb_ok   = HREADY & ~lock_ext[gidx] & (beats_nxt <= 4'd1);

   always_comb begin
      winner = DEF_IDX;
      found  = 1'b0;
      idx    = 4'd0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = 4'((int'(gidx) + i) % NUM_MASTERS);
         if (!found && elig[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
      grant_nxt = GRANT_ONE << winner;
   end

   always_ff @(posedge clock) begin
      if (!HRESETn) begin
         gidx       <= DEF_IDX;
         beats_left <= 4'd0;
         split_mask <= 16'd0;
         HGRANT     <= GRANT_ONE << DEF_IDX;
         HMASTER    <= DEF_IDX;
         HMASTLOCK  <= 1'b0;
      end else begin
         beats_left <= beats_nxt;
         split_mask <= split_nxt;
         if (arb_ok) begin
            gidx   <= winner;
            HGRANT <= grant_nxt;
         end
         if (HREADY) begin
            HMASTER   <= gidx;
            HMASTLOCK <= lock_ext[gidx];
         end
      end
   end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed vector table, hand-written wait/split sequences,
// then randomized traffic checked against a behavioural arbitration model.
module tb_ahb_bus_arbiter;

   localparam int N   = 4;
   localparam int DEF = 0;

   logic         clock = 1'b0;
   logic         HRESETn;
   logic [N-1:0] HBUSREQ, HLOCK;
   logic [1:0]   HTRANS;
   logic [2:0]   HBURST;
   logic         HREADY;
   logic [1:0]   HRESP;
   logic [15:0]  HSPLIT;
   logic [N-1:0] HGRANT;
   logic [3:0]   HMASTER;
   logic         HMASTLOCK;

   int n_pass  = 0;
   int n_total = 0;

   // model state
   int        m_owner, m_beats, m_master;
   bit        m_mlock;
   bit [15:0] m_split;

   ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
      .clock(clock), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
      .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
      .HSPLIT(HSPLIT), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  lock;
      logic [1:0]  trans;
      logic [2:0]  burst;
      logic        ready;
      logic [1:0]  resp;
      logic [15:0] split;
      logic [3:0]  e_grant;
      logic [3:0]  e_master;
      logic        e_mlock;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int burst_beats(input logic [2:0] b);
      case (b)
         3'd0, 3'd1: return 1;
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         default:    return 16;
      endcase
   endfunction

   function automatic int pick(input int owner, input bit [15:0] eligible);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (owner + k) % N;
         if (eligible[c]) return c;
      end
      return DEF;
   endfunction

   task automatic model_edge();
      int        nb, prev;
      bit [15:0] ns, lk;
      if (!HRESETn) begin
         m_owner = DEF; m_beats = 0; m_split = '0; m_master = DEF; m_mlock = 1'b0;
         return;
      end
      lk   = 16'(HLOCK);
      prev = m_owner;
      nb   = m_beats;
      if (HREADY) begin
         if (HRESP != 2'd0) nb = 0;
         else if (HTRANS == 2'd2) nb = burst_beats(HBURST) - 1;
         else if (HTRANS == 2'd3 && nb > 0) nb = nb - 1;
      end
      ns = m_split;
      for (int i = 0; i < N; i++) if (HSPLIT[i]) ns[i] = 1'b0;
      if (HRESP == 2'd3 && !HREADY) ns[m_master] = 1'b1;
      if (HREADY && !lk[prev] && nb <= 1)
         m_owner = pick(prev, 16'(HBUSREQ) & ~m_split);
      if (HREADY) begin
         m_master = prev;
         m_mlock  = lk[prev];
      end
      m_beats = nb;
      m_split = ns;
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      chk("grant", int'(HGRANT), 1 << m_owner);
      chk("hmaster", int'(HMASTER), m_master);
      chk("hmastlock", int'(HMASTLOCK), int'(m_mlock));
      chk("onehot", int'($onehot(HGRANT)), 1);
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                        input logic [2:0] burst, input logic ready, input logic [1:0] resp,
                        input logic [15:0] split);
      HRESETn = 1'b1; HBUSREQ = req; HLOCK = lock; HTRANS = trans; HBURST = burst;
      HREADY = ready; HRESP = resp; HSPLIT = split;
   endtask

   initial begin
      HRESETn = 1'b0; HBUSREQ = '0; HLOCK = '0; HTRANS = 2'd0; HBURST = 3'd0;
      HREADY = 1'b1; HRESP = 2'd0; HSPLIT = 16'd0;

      // reset/idle, round robin, INCR4 hold, lock hold and release
      tbl[0]  = '{1'b0, 4'h0, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0001, 4'd0, 1'b0};
      tbl[1]  = '{1'b0, 4'h0, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0001, 4'd0, 1'b0};
      tbl[2]  = '{1'b1, 4'h0, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0001, 4'd0, 1'b0};
      tbl[3]  = '{1'b1, 4'h0, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0001, 4'd0, 1'b0};
      tbl[4]  = '{1'b1, 4'hE, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0010, 4'd0, 1'b0};
      tbl[5]  = '{1'b1, 4'hE, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0100, 4'd1, 1'b0};
      tbl[6]  = '{1'b1, 4'hE, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b1000, 4'd2, 1'b0};
      tbl[7]  = '{1'b1, 4'hE, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0010, 4'd3, 1'b0};
      tbl[8]  = '{1'b1, 4'hE, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0100, 4'd1, 1'b0};
      tbl[9]  = '{1'b1, 4'hC, 4'h0, 2'd2, 3'd3, 1'b1, 2'd0, 16'h0, 4'b0100, 4'd2, 1'b0};
      tbl[10] = '{1'b1, 4'hC, 4'h0, 2'd3, 3'd3, 1'b1, 2'd0, 16'h0, 4'b0100, 4'd2, 1'b0};
      tbl[11] = '{1'b1, 4'h8, 4'h0, 2'd3, 3'd3, 1'b1, 2'd0, 16'h0, 4'b1000, 4'd2, 1'b0};
      tbl[12] = '{1'b1, 4'h8, 4'h0, 2'd3, 3'd3, 1'b1, 2'd0, 16'h0, 4'b1000, 4'd3, 1'b0};
      tbl[13] = '{1'b1, 4'h8, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0, 16'h0, 4'b1000, 4'd3, 1'b0};
      tbl[14] = '{1'b1, 4'h2, 4'h2, 2'd0, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0010, 4'd3, 1'b0};
      tbl[15] = '{1'b1, 4'h3, 4'h2, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0010, 4'd1, 1'b1};
      tbl[16] = '{1'b1, 4'h3, 4'h2, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0010, 4'd1, 1'b1};
      tbl[17] = '{1'b1, 4'h3, 4'h2, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0010, 4'd1, 1'b1};
      tbl[18] = '{1'b1, 4'h1, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0001, 4'd1, 1'b0};
      tbl[19] = '{1'b1, 4'h1, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0, 4'b0001, 4'd0, 1'b0};

      for (int i = 0; i < 20; i++) begin
         HRESETn = tbl[i].rst; HBUSREQ = tbl[i].req; HLOCK = tbl[i].lock;
         HTRANS = tbl[i].trans; HBURST = tbl[i].burst; HREADY = tbl[i].ready;
         HRESP = tbl[i].resp; HSPLIT = tbl[i].split;
         tick();
         chk($sformatf("tbl%0d_grant", i), int'(HGRANT), int'(tbl[i].e_grant));
         chk($sformatf("tbl%0d_master", i), int'(HMASTER), int'(tbl[i].e_master));
         chk($sformatf("tbl%0d_mlock", i), int'(HMASTLOCK), int'(tbl[i].e_mlock));
      end

      // INCR4 with three wait states on beat 2: handover slips by exactly three edges
      drive(4'h4, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0, 16'h0); tick();
      chk("ws_own", int'(HGRANT), 4'b0100);
      drive(4'hC, 4'h0, 2'd2, 3'd3, 1'b1, 2'd0, 16'h0); tick();
      chk("ws_b1", int'(HGRANT), 4'b0100);
      for (int w = 0; w < 3; w++) begin
         drive(4'h8, 4'h0, 2'd3, 3'd3, 1'b0, 2'd0, 16'h0); tick();
         chk($sformatf("ws_wait%0d_grant", w), int'(HGRANT), 4'b0100);
         chk($sformatf("ws_wait%0d_master", w), int'(HMASTER), 2);
      end
      drive(4'h8, 4'h0, 2'd3, 3'd3, 1'b1, 2'd0, 16'h0); tick();
      chk("ws_b2", int'(HGRANT), 4'b0100);
      tick();
      chk("ws_b3_handover", int'(HGRANT), 4'b1000);
      chk("ws_b3_master", int'(HMASTER), 2);
      tick();
      chk("ws_b4_master", int'(HMASTER), 3);

      // SPLIT on master 3 excludes it until HSPLIT releases it
      drive(4'hA, 4'h0, 2'd0, 3'd0, 1'b0, 2'd3, 16'h0); tick();
      chk("sp_hold", int'(HGRANT), 4'b1000);
      drive(4'hA, 4'h0, 2'd0, 3'd0, 1'b1, 2'd3, 16'h0); tick();
      chk("sp_regrant", int'(HGRANT), 4'b0010);
      for (int k = 0; k < 5; k++) begin
         drive(4'hA, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0); tick();
         chk($sformatf("sp_masked%0d", k), int'(HGRANT), 4'b0010);
      end
      drive(4'hA, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0008); tick();
      chk("sp_release_edge", int'(HGRANT), 4'b0010);
      drive(4'hA, 4'h0, 2'd2, 3'd0, 1'b1, 2'd0, 16'h0); tick();
      chk("sp_released", int'(HGRANT), 4'b1000);
      drive(4'h8, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0, 16'h0); tick();
      chk("sp_master3", int'(HMASTER), 3);
      // set and release on the same edge: set wins, master 3 stays masked
      drive(4'h8, 4'h0, 2'd0, 3'd0, 1'b0, 2'd3, 16'h0008); tick();
      drive(4'h8, 4'h0, 2'd0, 3'd0, 1'b1, 2'd3, 16'h0); tick();
      chk("sp_same_default", int'(HGRANT), 4'b0001);
      for (int k = 0; k < 3; k++) begin
         drive(4'h8, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0, 16'h0); tick();
         chk($sformatf("sp_same_masked%0d", k), int'(HGRANT), 4'b0001);
      end

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         HRESETn = ($urandom_range(0, 63) != 0);
         HBUSREQ = 4'($urandom);
         HLOCK   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         HTRANS  = 2'($urandom);
         HBURST  = 3'($urandom);
         HREADY  = ($urandom_range(0, 3) != 0);
         HRESP   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
         HSPLIT  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Multi-master AHB arbiter that shares the AHB bus among up to 16 masters.
- Drives HGRANT to the masters, and HMASTER/HMASTLOCK to the slave side, where every slave samples them alongside HADDR/HTRANS.
- Round-robin priority with a default master; honours locked transfers and fixed-length bursts.
- Tracks SPLIT responses and slave HSPLIT releases so that split masters are excluded until released.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16)
- DEFAULT_MASTER, 0, master index granted when no eligible request exists (must be < NUM_MASTERS)

Ports:
- clock  input  1  bus clock; all state updates on its rising edge
- HRESETn  input  1  synchronous, active-low reset
- HBUSREQ  input  NUM_MASTERS  per-master bus request
- HLOCK  input  NUM_MASTERS  per-master locked-transfer request
- HTRANS  input  2  transfer type from the muxed master (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
- HBURST  input  3  burst type from the muxed master
- HREADY  input  1  bus ready (muxed slave HREADY)
- HRESP  input  2  slave response (0 OKAY, 1 ERROR, 2 RETRY, 3 SPLIT)
- HSPLIT  input  16  OR of all slaves' HSPLIT; bit i releases master i
- HGRANT  output  NUM_MASTERS  one-hot grant, registered
- HMASTER  output  4  index of the master owning the current address phase, registered
- HMASTLOCK  output  1  current address phase is locked, registered

Behaviour:
- Reset (HRESETn=0 at a clock edge):
  - HGRANT = one-hot(DEFAULT_MASTER); HMASTER = DEFAULT_MASTER; HMASTLOCK = 0.
  - split_mask = 0; beats_left = 0; gidx = DEFAULT_MASTER.
  - Reset mid-burst or mid-lock abandons all state immediately.
- Internal state:
  - gidx: index of the currently granted master.
  - beats_left: 4-bit count of burst beats remaining.
  - split_mask: NUM_MASTERS bits; a set bit excludes that master from arbitration.
- Burst tracking, on a clock edge with HREADY=1:
  - HTRANS=NONSEQ loads beats_left = burst_len-1, where burst_len is 1 for SINGLE/INCR, 4 for WRAP4/INCR4, 8 for WRAP8/INCR8, 16 for WRAP16/INCR16.
  - HTRANS=SEQ with beats_left>0 decrements beats_left.
  - IDLE/BUSY leave beats_left unchanged.
  - HRESP = ERROR, RETRY or SPLIT clears beats_left to 0, which terminates the burst.
- Arbitration window: arb_ok = HREADY & ~HLOCK[gidx] & (beats_left <= 1).
  - beats_left is evaluated after this cycle's update, so the grant moves during the second-to-last beat, as AHB requires.
  - INCR (undefined length) is always preemptible.
- Arbitration, when arb_ok=1:
  - Eligible set = HBUSREQ & ~split_mask.
  - Winner is the first set bit searching upward from (gidx+1) mod NUM_MASTERS, wrapping around, with gidx itself checked last.
  - If the eligible set is empty, winner = DEFAULT_MASTER, even if DEFAULT_MASTER is split-masked (it must drive IDLE).
  - On the next edge: HGRANT = one-hot(winner); gidx = winner.
  - When arb_ok=0, HGRANT and gidx hold.
- Address-phase handover, on an edge with HREADY=1:
  - HMASTER <= gidx as it was before this edge's update, i.e. HMASTER lags HGRANT by one HREADY cycle.
  - HMASTLOCK <= HLOCK[gidx].
  - When HREADY=0, HMASTER and HMASTLOCK hold.
- Locking: while HLOCK[gidx]=1, the grant is held regardless of other requests and of burst state.
- Split tracking, per edge:
  - Bit i of split_mask clears when HSPLIT[i]=1.
  - Bit HMASTER sets when HRESP=SPLIT and HREADY=0 (first cycle of the two-cycle SPLIT response).
  - If set and clear target the same bit in the same cycle, set wins.
  - HSPLIT bits at or above NUM_MASTERS are ignored.
- Masking the currently granted master does not itself force a regrant; the regrant occurs at the next arb_ok.
- RETRY gets no special handling: the master keeps HBUSREQ and re-arbitrates normally.
- HGRANT is always exactly one-hot; no combinational path exists from any input to any output.

Test Plan:
- Reset then idle: HRESETn low 2 cycles, HBUSREQ=0 -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0 held every cycle.
- Round-robin: masters 1, 2 and 3 request continuously, SINGLE transfers, HREADY=1 -> HGRANT sequence 0010, 0100, 1000, 0010; HMASTER follows one cycle later (1, 2, 3, 1).
- Fixed burst hold: master 2 issues INCR4 (NONSEQ + 3 SEQ, HREADY=1) while master 3 requests -> HGRANT stays 0100 until the third beat's edge and becomes 1000 during the fourth beat; HMASTER=3 only after beat 4 completes.
- Wait states: as the previous scenario with HREADY=0 inserted for 3 cycles on beat 2 -> HGRANT, HMASTER and beats_left frozen during the wait; handover is delayed by exactly 3 cycles.
- Lock: master 1 holds HLOCK=1 and HBUSREQ=1 while master 0 requests for 10 cycles -> HGRANT=0010 throughout, HMASTLOCK=1; one cycle after HLOCK drops with HREADY=1, HGRANT=0001.
- Split/release: master 3 receives SPLIT (HRESP=3, HREADY=0 then 1) while requesting -> split_mask[3]=1 and master 3 is never granted; a single-cycle HSPLIT=16'h0008 clears the mask and master 3 is granted at the next arbitration. A same-cycle SPLIT set and HSPLIT clear on master 3 leaves it masked.
